// File: rtl/mem_arb_pkg.sv
// Shared constants and helpers for the multi-port RAM arbiter.
package mem_arb_pkg;

    localparam int MODE_RR    = 0;  // round-robin arbitration
    localparam int MODE_FIXED = 1;  // fixed priority, lowest index wins

    localparam int DEF_ADDR_W = 12;
    localparam int DEF_DATA_W = 32;

    // Width of a port index; kept at one bit minimum so single-port builds stay legal.
    function automatic int port_idx_w(input int num_ports);
        return (num_ports > 1) ? $clog2(num_ports) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// One-hot arbiter: round-robin with a rotating pointer, or fixed lowest-index priority.
module rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int MODE      = MODE_RR
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_PORTS-1:0] req,
    output logic [NUM_PORTS-1:0] grant
);

    localparam int                   PTR_W = port_idx_w(NUM_PORTS);
    localparam logic [NUM_PORTS-1:0] ONE   = NUM_PORTS'(1);

    logic [PTR_W-1:0]     ptr_q;
    logic [PTR_W-1:0]     ptr_d;
    logic [NUM_PORTS-1:0] eligible;
    logic [NUM_PORTS-1:0] masked;
    logic [NUM_PORTS-1:0] pick_src;

    // Lowest requester at or above the pointer wins; if none, wrap to the lowest requester overall.
    always_comb begin
        if (MODE == MODE_FIXED) begin
            eligible = '1;
        end else begin
            eligible = ~((ONE << ptr_q) - ONE);
        end
        masked   = req & eligible;
        pick_src = (|masked) ? masked : req;
        grant    = pick_src & (~pick_src + ONE);
        if (!reset) begin
            grant = '0;
        end
    end

    // Move the pointer just past the winner; hold it when nothing is granted.
    always_comb begin
        ptr_d = ptr_q;
        if (MODE != MODE_FIXED) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (grant[i]) begin
                    ptr_d = (i == NUM_PORTS - 1) ? '0 : PTR_W'(i + 1);
                end
            end
        end
    end

    // Pointer register; port 0 has top priority after reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous RAM among NUM_PORTS requesters with tagged read responses.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MODE      = MODE_RR
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NUM_PORTS-1:0]        req_valid,
    input  logic [NUM_PORTS-1:0]        req_wren,
    input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
    input  logic [NUM_PORTS*DATA_W-1:0] req_data,
    output logic [NUM_PORTS-1:0]        req_ready,
    output logic [NUM_PORTS-1:0]        rsp_valid,
    output logic [DATA_W-1:0]           rsp_data,
    output logic [ADDR_W-1:0]           mem_address,
    output logic [DATA_W-1:0]           mem_data,
    output logic                        mem_wren,
    input  logic [DATA_W-1:0]           mem_q
);

    localparam int PTR_W = port_idx_w(NUM_PORTS);

    logic             rsp_pend_q;
    logic             rsp_pend_d;
    logic [PTR_W-1:0] rsp_port_q;
    logic [PTR_W-1:0] rsp_port_d;

    rr_arbiter #(
        .NUM_PORTS (NUM_PORTS),
        .MODE      (MODE)
    ) u_arb (
        .clock (clock),
        .reset (reset),
        .req   (req_valid),
        .grant (req_ready)
    );

    // Steer the granted port onto the RAM; an idle cycle drives all zeros.
    always_comb begin
        mem_address = '0;
        mem_data    = '0;
        mem_wren    = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (req_ready[i]) begin
                mem_address = req_addr[i*ADDR_W +: ADDR_W];
                mem_data    = req_data[i*DATA_W +: DATA_W];
                mem_wren    = req_wren[i];
            end
        end
    end

    // Remember which port owns the RAM output on the next cycle (reads only).
    always_comb begin
        rsp_pend_d = 1'b0;
        rsp_port_d = rsp_port_q;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (req_ready[i] && !req_wren[i]) begin
                rsp_pend_d = 1'b1;
                rsp_port_d = PTR_W'(i);
            end
        end
    end

    // Response tag registers; reset drops any read still in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rsp_pend_q <= 1'b0;
            rsp_port_q <= '0;
        end else begin
            rsp_pend_q <= rsp_pend_d;
            rsp_port_q <= rsp_port_d;
        end
    end

    // Route RAM read data to the tagged port; the shared bus is zero when nobody owns it.
    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            rsp_valid[i] = rsp_pend_q && (rsp_port_q == PTR_W'(i));
        end
        rsp_data = rsp_pend_q ? mem_q : '0;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: three instances (2-port RR with RAM, 3-port RR, 3-port fixed).
module tb_mem_arbiter;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;
    bit sim_done = 1'b0;

    // Instance A: 2 ports, round-robin, backed by a real RAM.
    logic [1:0]  a_valid, a_wren, a_ready, a_rsp_valid;
    logic [23:0] a_addr;
    logic [63:0] a_data;
    logic [31:0] a_rsp_data, a_mem_data, a_mem_q;
    logic [11:0] a_mem_address;
    logic        a_mem_wren;
    logic [31:0] ram [0:4095];

    // Instances B (3-port RR) and C (3-port fixed); their "RAM" returns the address.
    logic [2:0]  b_valid, b_wren, b_ready, b_rsp_valid;
    logic [35:0] b_addr;
    logic [95:0] b_data;
    logic [31:0] b_rsp_data, b_mem_data, b_mem_q;
    logic [11:0] b_mem_address;
    logic        b_mem_wren;

    logic [2:0]  c_valid, c_wren, c_ready, c_rsp_valid;
    logic [35:0] c_addr;
    logic [95:0] c_data;
    logic [31:0] c_rsp_data, c_mem_data, c_mem_q;
    logic [11:0] c_mem_address;
    logic        c_mem_wren;

    mem_arbiter #(.NUM_PORTS(2), .ADDR_W(12), .DATA_W(32), .MODE(0)) dut_a (
        .clock(clock), .reset(reset), .req_valid(a_valid), .req_wren(a_wren),
        .req_addr(a_addr), .req_data(a_data), .req_ready(a_ready), .rsp_valid(a_rsp_valid),
        .rsp_data(a_rsp_data), .mem_address(a_mem_address), .mem_data(a_mem_data),
        .mem_wren(a_mem_wren), .mem_q(a_mem_q));

    mem_arbiter #(.NUM_PORTS(3), .ADDR_W(12), .DATA_W(32), .MODE(0)) dut_b (
        .clock(clock), .reset(reset), .req_valid(b_valid), .req_wren(b_wren),
        .req_addr(b_addr), .req_data(b_data), .req_ready(b_ready), .rsp_valid(b_rsp_valid),
        .rsp_data(b_rsp_data), .mem_address(b_mem_address), .mem_data(b_mem_data),
        .mem_wren(b_mem_wren), .mem_q(b_mem_q));

    mem_arbiter #(.NUM_PORTS(3), .ADDR_W(12), .DATA_W(32), .MODE(1)) dut_c (
        .clock(clock), .reset(reset), .req_valid(c_valid), .req_wren(c_wren),
        .req_addr(c_addr), .req_data(c_data), .req_ready(c_ready), .rsp_valid(c_rsp_valid),
        .rsp_data(c_rsp_data), .mem_address(c_mem_address), .mem_data(c_mem_data),
        .mem_wren(c_mem_wren), .mem_q(c_mem_q));

    // Synchronous RAMs with one-cycle read latency.
    always @(posedge clock) begin
        if (a_mem_wren) ram[a_mem_address] <= a_mem_data;
        a_mem_q <= ram[a_mem_address];
        b_mem_q <= {20'h0, b_mem_address};
        c_mem_q <= {20'h0, c_mem_address};
    end

    // Behavioural model state.
    int          m_ptr  [3];
    bit          m_pend [3];
    int          m_port [3];
    logic [31:0] m_rdata[3];
    logic [31:0] model_mem [0:4095];
    int          log_b[$];
    int          log_c[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Predict this cycle's outputs from the rules, compare, then advance the model to the next edge.
    task automatic check_inst(input int id, input int n, input int mode,
                              input logic [2:0] valid, input logic [2:0] wren,
                              input logic [11:0] addr [3], input logic [31:0] data [3],
                              input logic [2:0] act_ready, input logic [2:0] act_rv,
                              input logic [31:0] act_rd, input logic [11:0] act_addr,
                              input logic [31:0] act_data, input logic act_wren);
        int          g;
        int          idx;
        logic [2:0]  e_ready, e_rv;
        logic [31:0] e_rd, e_d;
        logic [11:0] e_a;
        logic        e_w;
        string       tag;
        tag = $sformatf("inst%0d", id);
        if (!reset) begin
            chk({tag, ".ready_in_reset"}, act_ready, 0);
            chk({tag, ".wren_in_reset"}, act_wren, 0);
            chk({tag, ".rsp_valid_in_reset"}, act_rv, 0);
            chk({tag, ".rsp_data_in_reset"}, act_rd, 0);
            m_ptr[id] = 0; m_pend[id] = 1'b0; m_port[id] = 0;
            return;
        end
        e_rv = m_pend[id] ? (3'b001 << m_port[id]) : 3'b000;
        e_rd = m_pend[id] ? m_rdata[id] : 32'h0;
        g = -1;
        for (int k = 0; k < n; k++) begin
            idx = (mode == 1) ? k : (m_ptr[id] + k) % n;
            if (g < 0 && valid[idx]) g = idx;
        end
        e_ready = (g >= 0) ? (3'b001 << g) : 3'b000;
        e_a = (g >= 0) ? addr[g] : 12'h0;
        e_d = (g >= 0) ? data[g] : 32'h0;
        e_w = (g >= 0) ? wren[g] : 1'b0;
        chk({tag, ".req_ready"}, act_ready, e_ready);
        chk({tag, ".rsp_valid"}, act_rv, e_rv);
        chk({tag, ".rsp_data"}, act_rd, e_rd);
        chk({tag, ".mem_address"}, act_addr, e_a);
        chk({tag, ".mem_data"}, act_data, e_d);
        chk({tag, ".mem_wren"}, act_wren, e_w);
        if (id == 1) log_b.push_back(g);
        if (id == 2) log_c.push_back(g);
        m_pend[id] = 1'b0;
        if (g >= 0) begin
            if (mode == 0) m_ptr[id] = (g + 1) % n;
            if (wren[g]) begin
                if (id == 0) model_mem[addr[g]] = data[g];
            end else begin
                m_pend[id]  = 1'b1;
                m_port[id]  = g;
                m_rdata[id] = (id == 0) ? model_mem[addr[g]] : {20'h0, addr[g]};
            end
        end
    endtask

    // Compare process: every falling edge, all three instances against the model.
    initial begin : compare
        logic [11:0] ad [3];
        logic [31:0] dd [3];
        forever begin
            @(negedge clock);
            if (!sim_done) begin
                for (int i = 0; i < 2; i++) begin
                    ad[i] = a_addr[i*12 +: 12];
                    dd[i] = a_data[i*32 +: 32];
                end
                ad[2] = 12'h0; dd[2] = 32'h0;
                check_inst(0, 2, 0, {1'b0, a_valid}, {1'b0, a_wren}, ad, dd, {1'b0, a_ready},
                           {1'b0, a_rsp_valid}, a_rsp_data, a_mem_address, a_mem_data, a_mem_wren);
                for (int i = 0; i < 3; i++) begin
                    ad[i] = b_addr[i*12 +: 12];
                    dd[i] = b_data[i*32 +: 32];
                end
                check_inst(1, 3, 0, b_valid, b_wren, ad, dd, b_ready, b_rsp_valid, b_rsp_data,
                           b_mem_address, b_mem_data, b_mem_wren);
                for (int i = 0; i < 3; i++) begin
                    ad[i] = c_addr[i*12 +: 12];
                    dd[i] = c_data[i*32 +: 32];
                end
                check_inst(2, 3, 1, c_valid, c_wren, ad, dd, c_ready, c_rsp_valid, c_rsp_data,
                           c_mem_address, c_mem_data, c_mem_wren);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_a(input int p, input logic v, input logic w,
                         input logic [11:0] ad, input logic [31:0] d);
        a_valid[p] = v;
        a_wren[p]  = w;
        a_addr[p*12 +: 12] = ad;
        a_data[p*32 +: 32] = d;
    endtask

    task automatic clear_all();
        a_valid = '0; a_wren = '0; a_addr = '0; a_data = '0;
        b_valid = '0; b_wren = '0; b_addr = '0; b_data = '0;
        c_valid = '0; c_wren = '0; c_addr = '0; c_data = '0;
    endtask

    // Directed stimulus with hand-computed literal expectations.
    initial begin : stim
        int exp_b [6];
        exp_b = '{0, 1, 2, 0, 1, 2};
        reset = 1'b1;
        clear_all();
        #2 reset = 1'b0;

        // Requests held during reset must not be granted.
        set_a(0, 1'b1, 1'b1, 12'h010, 32'hDEADBEEF);
        set_a(1, 1'b1, 1'b0, 12'h020, 32'h0);
        b_valid = 3'b111;
        @(negedge clock);
        chk("reset_ready_a", a_ready, 2'b00);
        chk("reset_wren_a", a_mem_wren, 1'b0);
        chk("reset_rsp_valid_a", a_rsp_valid, 2'b00);
        chk("reset_ready_b", b_ready, 3'b000);
        tick();
        reset = 1'b1;
        clear_all();

        // Single read: write DEADBEEF to 0x010 on port 0, read it back on port 1.
        set_a(0, 1'b1, 1'b1, 12'h010, 32'hDEADBEEF);
        tick();
        set_a(0, 1'b0, 1'b0, 12'h0, 32'h0);
        set_a(1, 1'b1, 1'b0, 12'h010, 32'h0);
        tick();
        clear_all();
        @(negedge clock);
        chk("single_rsp_valid", a_rsp_valid, 2'b10);
        chk("single_rsp_data", a_rsp_data, 32'hDEADBEEF);

        // Preload 0x001..0x004 with 0x11..0x44, then four back-to-back reads on port 0.
        for (int i = 1; i <= 4; i++) begin
            tick();
            set_a(0, 1'b1, 1'b1, 12'(i), 32'(i * 'h11));
        end
        tick();
        set_a(0, 1'b1, 1'b0, 12'h001, 32'h0);
        tick();
        for (int i = 1; i <= 4; i++) begin
            if (i < 4) set_a(0, 1'b1, 1'b0, 12'(i + 1), 32'h0);
            else clear_all();
            @(negedge clock);
            chk($sformatf("b2b_rsp_valid_%0d", i), a_rsp_valid, 2'b01);
            chk($sformatf("b2b_rsp_data_%0d", i), a_rsp_data, 32'(i * 'h11));
            tick();
        end

        // Write 0x0FF then read it in the very next cycle.
        set_a(0, 1'b1, 1'b1, 12'h0FF, 32'h5A5A5A5A);
        @(negedge clock);
        chk("wr_mem_wren", a_mem_wren, 1'b1);
        tick();
        set_a(0, 1'b1, 1'b0, 12'h0FF, 32'h0);
        tick();
        clear_all();
        @(negedge clock);
        chk("wr_then_rd_data", a_rsp_data, 32'h5A5A5A5A);
        tick();
        @(negedge clock);
        chk("idle_mem_wren", a_mem_wren, 1'b0);
        tick();

        // Fairness (B, all valid) and fixed priority (C, ports 0 and 2) for six cycles.
        log_b.delete();
        log_c.delete();
        b_valid = 3'b111; b_addr = {12'h300, 12'h200, 12'h100};
        c_valid = 3'b101; c_addr = {12'h3C0, 12'h000, 12'h0C0};
        @(negedge clock);
        chk("rr_first_addr", b_mem_address, 12'h100);
        for (int i = 0; i < 6; i++) tick();
        clear_all();
        chk("rr_grant_count", log_b.size(), 6);
        for (int i = 0; i < 6 && i < log_b.size(); i++)
            chk($sformatf("rr_grant_%0d", i), log_b[i], exp_b[i]);
        chk("fixed_grant_count", log_c.size(), 6);
        for (int i = 0; i < log_c.size(); i++)
            chk($sformatf("fixed_grant_%0d", i), log_c[i], 0);

        // Reset lands while a read is in flight: the response is dropped.
        tick();
        set_a(1, 1'b1, 1'b0, 12'h010, 32'h0);
        tick();
        clear_all();
        #1 reset = 1'b0;
        @(negedge clock);
        chk("rstmid_rsp_valid", a_rsp_valid, 2'b00);
        tick();
        reset = 1'b1;
        set_a(0, 1'b1, 1'b0, 12'h001, 32'h0);
        set_a(1, 1'b1, 1'b0, 12'h002, 32'h0);
        @(negedge clock);
        chk("rstmid_after_rsp_valid", a_rsp_valid, 2'b00);
        chk("rstmid_port0_priority", a_ready, 2'b01);
        tick();
        clear_all();
        @(negedge clock);
        chk("rstmid_next_rsp_valid", a_rsp_valid, 2'b01);
        chk("rstmid_next_rsp_data", a_rsp_data, 32'h11);
        tick();

        sim_done = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
